// File: rtl/int_arith_seq_if.sv
// Issue/result bundle between the CPU execute stage (master) and the
// sequential integer arithmetic unit (slave).
interface int_arith_seq_if;
    logic        start;
    logic [2:0]  op;
    logic        is64;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [1:0]  result_type;
    logic [3:0]  trap;

    modport master (
        output start, op, is64, a, b,
        input  busy, done, result, result_type, trap
    );

    modport slave (
        input  start, op, is64, a, b,
        output busy, done, result, result_type, trap
    );
endinterface

// File: rtl/int_arith_seq.sv
// Sequential Wasm i32/i64 add/sub/mul/div/rem unit: one bit per cycle for
// mul and div/rem, with Wasm trap reporting on the done pulse.
module int_arith_seq #(
    parameter bit USE_64B = 1'b1,
    parameter bit DIV_EN  = 1'b1
) (
    input logic            clk,
    input logic            reset,
    int_arith_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_CALC, S_FIX, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV_S, OP_DIV_U, OP_REM_S, OP_REM_U, OP_RSVD
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        w64_q, w64_d;
    logic [63:0] x_q, x_d;      // a / multiplicand / dividend-then-quotient
    logic [63:0] y_q, y_d;      // b / multiplier / divisor
    logic [63:0] p_q, p_d;      // product accumulator / partial remainder
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;
    logic [1:0]  rtype_q, rtype_d;
    logic [3:0]  trap_q, trap_d;

    function automatic logic [63:0] fit(input logic [63:0] v, input logic w64);
        return w64 ? v : {32'd0, v[31:0]};
    endfunction

    logic        sign_a, sign_b, is_signed, is_divrem, is_long;
    logic [63:0] int_min, minus_one;
    logic [3:0]  dec_trap;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sign_a    = w64_q ? x_q[63] : x_q[31];
        sign_b    = w64_q ? y_q[63] : y_q[31];
        is_signed = op_q inside {OP_DIV_S, OP_REM_S};
        is_divrem = op_q inside {OP_DIV_S, OP_DIV_U, OP_REM_S, OP_REM_U};
        int_min   = w64_q ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        minus_one = fit('1, w64_q);
        dec_trap  = 4'd0;
        if (op_q == OP_RSVD || (is_divrem && !DIV_EN))
            dec_trap = 4'd3;
        else if (is_divrem && y_q == 64'd0)
            dec_trap = 4'd1;
        else if (op_q == OP_DIV_S && x_q == int_min && y_q == minus_one)
            dec_trap = 4'd2;
        is_long = (op_q == OP_MUL || is_divrem) && dec_trap == 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_DECODE;
            S_DECODE: state_d = is_long ? S_CALC : S_DONE;
            S_CALC:   if (cnt_q == 6'd0) state_d = S_FIX;
            S_FIX:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = state_q != S_IDLE;
        bus.done        = state_q == S_DONE;
        bus.result      = result_q;
        bus.result_type = rtype_q;
        bus.trap        = trap_q;
    end

    logic [63:0] mag_a, mag_b, fixed;
    logic [64:0] rem_try, rem_sub;
    logic        w64_in;

    always_comb begin
        op_d     = op_q;
        w64_d    = w64_q;
        x_d      = x_q;
        y_d      = y_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        rtype_d  = rtype_q;
        trap_d   = trap_q;
        w64_in   = USE_64B && bus.is64;
        mag_a    = (is_signed && sign_a) ? fit(-x_q, w64_q) : x_q;
        mag_b    = (is_signed && sign_b) ? fit(-y_q, w64_q) : y_q;
        rem_try  = {p_q, x_q[63]};
        rem_sub  = rem_try - {1'b0, y_q};
        fixed    = 64'd0;

        unique case (state_q)
            S_IDLE: if (bus.start) begin
                op_d  = op_e'(bus.op);
                w64_d = w64_in;
                x_d   = fit(bus.a, w64_in);
                y_d   = fit(bus.b, w64_in);
            end
            S_DECODE: if (!is_long) begin
                result_d = (dec_trap != 4'd0) ? 64'd0
                         : fit((op_q == OP_SUB) ? x_q - y_q : x_q + y_q, w64_q);
                rtype_d  = {1'b0, w64_q};
                trap_d   = dec_trap;
            end else begin
                cnt_d = w64_q ? 6'd63 : 6'd31;
                p_d   = 64'd0;
                if (is_divrem) begin
                    // Dividend is left-aligned so its MSB always leaves through bit 63.
                    x_d    = w64_q ? mag_a : {mag_a[31:0], 32'd0};
                    y_d    = mag_b;
                    qneg_d = is_signed && (sign_a ^ sign_b);
                    rneg_d = is_signed && sign_a;
                end
            end
            S_CALC: begin
                if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
                if (op_q == OP_MUL) begin
                    if (y_q[0]) p_d = p_q + x_q;
                    x_d = {x_q[62:0], 1'b0};
                    y_d = {1'b0, y_q[63:1]};
                end else if (!rem_sub[64]) begin
                    p_d = rem_sub[63:0];
                    x_d = {x_q[62:0], 1'b1};
                end else begin
                    p_d = rem_try[63:0];
                    x_d = {x_q[62:0], 1'b0};
                end
            end
            S_FIX: begin
                if (op_q == OP_MUL)                               fixed = p_q;
                else if (op_q == OP_DIV_S || op_q == OP_DIV_U)   fixed = qneg_q ? -x_q : x_q;
                else                                              fixed = rneg_q ? -p_q : p_q;
                result_d = fit(fixed, w64_q);
                rtype_d  = {1'b0, w64_q};
                trap_d   = 4'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_ADD;
            w64_q    <= 1'b0;
            x_q      <= 64'd0;
            y_q      <= 64'd0;
            p_q      <= 64'd0;
            cnt_q    <= 6'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
            rtype_q  <= 2'd0;
            trap_q   <= 4'd0;
        end else begin
            op_q     <= op_d;
            w64_q    <= w64_d;
            x_q      <= x_d;
            y_q      <= y_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            rtype_q  <= rtype_d;
            trap_q   <= trap_d;
        end
    end
endmodule

// File: tb/tb_int_arith_seq.sv
// Scoreboard bench for int_arith_seq: the driver pushes model results, an
// independent monitor pops and compares them on every done pulse.
module tb_int_arith_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int_arith_seq_if bus ();

    int_arith_seq dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  rtype;
        logic [3:0]  trap;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference semantics from the Wasm rules, in plain signed/unsigned arithmetic.
    function automatic void model(input logic [2:0] op, input bit w64,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] res, output logic [3:0] trap,
                                  output int lat);
        logic [63:0] m, a, b;
        longint      sa, sb, smin;
        m    = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & m;
        b    = b_in & m;
        sa   = w64 ? longint'(a) : longint'($signed(a[31:0]));
        sb   = w64 ? longint'(b) : longint'($signed(b[31:0]));
        smin = w64 ? longint'(64'h8000_0000_0000_0000) : -64'sd2147483648;
        res  = 64'd0;
        trap = 4'd0;
        case (op)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a * b;
            3'd3: if (b == 0) trap = 1;
                  else if (sa == smin && sb == -1) trap = 2;
                  else res = 64'(sa / sb);
            3'd4: if (b == 0) trap = 1; else res = a / b;
            3'd5: if (b == 0) trap = 1;
                  else if (sb == -1) res = 64'd0;
                  else res = 64'(sa % sb);
            3'd6: if (b == 0) trap = 1; else res = a % b;
            default: trap = 3;
        endcase
        res = (trap != 0) ? 64'd0 : (res & m);
        lat = (op >= 3'd2 && op <= 3'd6 && trap == 0) ? (w64 ? 66 : 34) : 1;
    endfunction

    task automatic issue(input logic [2:0] op, input bit w64,
                         input logic [63:0] a, input logic [63:0] b, input bit track);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("issue_wait_timeout", 64'd1, 64'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.is64  = w64;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (track) begin
            model(op, w64, a, b, e.res, e.trap, e.lat);
            e.rtype = {1'b0, w64};
            e.acc   = cyc;
            exp_q.push_back(e);
        end
    endtask

    logic prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_done) begin
            check("done_single_pulse", 64'(bus.done), 64'd0);
            check("busy_drops_with_done", 64'(bus.busy), 64'd0);
        end
        prev_done <= bus.done;
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("result_type", 64'(bus.result_type), 64'(e.rtype));
                check("trap", 64'(bus.trap), 64'(e.trap));
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        logic [2:0]  rop;
        bit          rw;
        int          guard;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.is64  = 1'b0;
        bus.a     = 64'd0;
        bus.b     = 64'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_result_type", 64'(bus.result_type), 64'd0);
        check("reset_trap", 64'(bus.trap), 64'd0);
        rst_n = 1'b1;

        issue(3'd1, 1'b1, 64'd3, 64'd2, 1'b1);
        issue(3'd1, 1'b0, 64'd0, 64'd1, 1'b1);
        issue(3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);

        // i64 mul with a stray start pulse mid-operation that must be ignored
        issue(3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 64'd1;
        bus.b     = 64'd1;
        @(negedge clk);
        bus.start = 1'b0;

        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(3'd4, 1'b0, 64'd7, 64'd2, 1'b1);
        issue(3'd6, 1'b0, 64'd7, 64'd2, 1'b1);
        issue(3'd4, 1'b1, 64'd1234, 64'd0, 1'b1);
        issue(3'd3, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
        issue(3'd5, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
        issue(3'd3, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        issue(3'd7, 1'b1, 64'd9, 64'd9, 1'b1);

        // Abort an i64 mul with reset around cycle 10: outputs clear at once, no done
        issue(3'd2, 1'b1, 64'h0123_4567_89AB_CDEF, 64'd77, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_result", bus.result, 64'd0);
        check("abort_result_type", 64'(bus.result_type), 64'd0);
        check("abort_trap", 64'(bus.trap), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 1'b0, 64'd5, 64'd6, 1'b1);

        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: rb = 64'd0;
                1: rb = 64'($urandom_range(1, 15));
                2: begin
                    ra = rw ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                    rb = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: rb = {$urandom, 32'd0} >> $urandom_range(0, 60);
                default: ;
            endcase
            issue(rop, rw, ra, rb, 1'b1);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
